// File: rtl/mode_sequencer_if.sv
// mode_sequencer_if: host/VIO and stimulus-side signal bundle for mode_sequencer.
interface mode_sequencer_if #(parameter int DWELL_W = 24);
  logic               START;
  logic               ABORT;
  logic [7:0]         FIRST_MODE;
  logic [7:0]         LAST_MODE;
  logic [DWELL_W-1:0] DWELL;
  logic               PHY_INIT;
  logic [63:0]        ERR_CNT;
  logic [7:0]         MAIN_MODE;
  logic [7:0]         SUB_MODE;
  logic               CLR;
  logic               BUSY;
  logic               DONE;
  logic               CFG_ERR;
  logic [7:0]         FAIL_CNT;
  logic [7:0]         FIRST_FAIL;
  modport master (
    output START, ABORT, FIRST_MODE, LAST_MODE, DWELL, PHY_INIT, ERR_CNT,
    input  MAIN_MODE, SUB_MODE, CLR, BUSY, DONE, CFG_ERR, FAIL_CNT, FIRST_FAIL
  );
  modport slave (
    input  START, ABORT, FIRST_MODE, LAST_MODE, DWELL, PHY_INIT, ERR_CNT,
    output MAIN_MODE, SUB_MODE, CLR, BUSY, DONE, CFG_ERR, FAIL_CNT, FIRST_FAIL
  );
endinterface

// File: rtl/mode_sequencer.sv
// mode_sequencer: steps MAIN_MODE over [FIRST..LAST], clear/settle/dwell/check per run, pass/fail summary.
// Define MODE_SEQ_SUBSWEEP_EN to run every mode twice (SUB_MODE 0 then 1).
module mode_sequencer #(
  parameter int DWELL_W      = 24,
  parameter int CLR_CYC      = 4,
  parameter int INIT_TIMEOUT = 1024
) (
  input  logic           CLK,
  input  logic           RSTX,
  mode_sequencer_if.slave bus
);
  localparam int TW = $clog2(INIT_TIMEOUT + 1);
  localparam int CW = DWELL_W > TW ? DWELL_W : TW;
  typedef enum logic [2:0] {IDLE, CLEAR, SETTLE, DWELL, CHECK, NEXT} state_t;
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [7:0]         last_q, last_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [7:0]         main_q, main_d;
  logic [7:0]         sub_q, sub_d;
  logic [7:0]         fail_cnt_q, fail_cnt_d;
  logic [7:0]         first_fail_q, first_fail_d;
  logic               done_q, done_d;
  logic               cfg_err_q, cfg_err_d;
  logic               fail;
  logic               sub_last;
  logic [CW-1:0]      dwell_end;
`ifdef MODE_SEQ_SUBSWEEP_EN
  assign sub_last = sub_q[0];
`else
  assign sub_last = 1'b1;
`endif
  // a zero dwell behaves as a single-cycle dwell
  assign dwell_end = (dwell_q == '0) ? '0 : CW'(dwell_q - 1'b1);
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    dwell_d      = dwell_q;
    main_d       = main_q;
    sub_d        = sub_q;
    fail_cnt_d   = fail_cnt_q;
    first_fail_d = first_fail_q;
    done_d       = 1'b0;
    cfg_err_d    = 1'b0;
    fail         = 1'b0;
    if (bus.ABORT) begin
      state_d = IDLE;
      main_d  = '0;
      sub_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (bus.START) begin
          if (bus.FIRST_MODE > bus.LAST_MODE) cfg_err_d = 1'b1;
          else begin
            fail_cnt_d   = '0;
            first_fail_d = 8'hFF;
            main_d       = bus.FIRST_MODE;
            sub_d        = '0;
            last_d       = bus.LAST_MODE;
            dwell_d      = bus.DWELL;
            cnt_d        = '0;
            state_d      = CLEAR;
          end
        end
        CLEAR: begin
          cnt_d   = (cnt_q == CW'(CLR_CYC - 1)) ? '0 : cnt_q + 1'b1;
          state_d = (cnt_q == CW'(CLR_CYC - 1)) ? SETTLE : CLEAR;
        end
        SETTLE: begin
          fail    = !bus.PHY_INIT && cnt_q == CW'(INIT_TIMEOUT - 1);
          cnt_d   = (bus.PHY_INIT || fail) ? '0 : cnt_q + 1'b1;
          state_d = bus.PHY_INIT ? DWELL : fail ? NEXT : SETTLE;
        end
        DWELL: begin
          cnt_d   = (cnt_q == dwell_end) ? '0 : cnt_q + 1'b1;
          state_d = (cnt_q == dwell_end) ? CHECK : DWELL;
        end
        CHECK: begin
          fail    = |bus.ERR_CNT;
          state_d = NEXT;
        end
        NEXT: begin
          // end test compares before incrementing, so LAST=255 never wraps
          if (!sub_last) begin
            sub_d   = 8'h01;
            state_d = CLEAR;
          end else begin
            sub_d   = '0;
            done_d  = main_q == last_q;
            main_d  = (main_q == last_q) ? main_q : main_q + 1'b1;
            state_d = (main_q == last_q) ? IDLE : CLEAR;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (fail) begin
      fail_cnt_d   = fail_cnt_q + {7'd0, fail_cnt_q != 8'hFF};
      first_fail_d = (first_fail_q == 8'hFF) ? main_q : first_fail_q;
    end
  end
  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_q       <= '0;
      dwell_q      <= '0;
      main_q       <= '0;
      sub_q        <= '0;
      fail_cnt_q   <= '0;
      first_fail_q <= 8'hFF;
      done_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      dwell_q      <= dwell_d;
      main_q       <= main_d;
      sub_q        <= sub_d;
      fail_cnt_q   <= fail_cnt_d;
      first_fail_q <= first_fail_d;
      done_q       <= done_d;
      cfg_err_q    <= cfg_err_d;
    end
  end
  assign bus.MAIN_MODE  = main_q;
  assign bus.SUB_MODE   = sub_q;
  assign bus.CLR        = state_q == CLEAR;
  assign bus.BUSY       = state_q != IDLE;
  assign bus.DONE       = done_q;
  assign bus.CFG_ERR    = cfg_err_q;
  assign bus.FAIL_CNT   = fail_cnt_q;
  assign bus.FIRST_FAIL = first_fail_q;
endmodule

// File: tb/tb_mode_sequencer.sv
// tb_mode_sequencer: directed checks of mode_sequencer; honours MODE_SEQ_SUBSWEEP_EN.
`timescale 1ns/1ps
module tb_mode_sequencer;
  localparam int CLR_CYC      = 4;
  localparam int INIT_TIMEOUT = 1024;
`ifdef MODE_SEQ_SUBSWEEP_EN
  localparam int RUNS = 2;
`else
  localparam int RUNS = 1;
`endif
  logic CLK = 1'b0;
  logic RSTX = 1'b0;
  int checks = 0;
  int errors = 0;
  int err_mode = -1;
  int bad_mode = -1;
  logic err_all = 1'b0;
  int n_busy, n_clr, n_runs, n_done, n_cfg, n_m7;
  logic zero_seen;
  logic clr_prev = 1'b0;
  logic [7:0] modes[$];
  logic [7:0] subs[$];
  mode_sequencer_if #(.DWELL_W(24)) bus();
  mode_sequencer #(.DWELL_W(24), .CLR_CYC(CLR_CYC), .INIT_TIMEOUT(INIT_TIMEOUT)) dut (
    .CLK(CLK), .RSTX(RSTX), .bus(bus));
  always #5 CLK = ~CLK;
  assign bus.ERR_CNT  = (err_all || int'(bus.MAIN_MODE) == err_mode) ? 64'd1 : 64'd0;
  assign bus.PHY_INIT = int'(bus.MAIN_MODE) != bad_mode;
  always @(negedge CLK) begin
    if (bus.BUSY) n_busy++;
    if (bus.CLR) n_clr++;
    if (bus.CLR && !clr_prev) begin
      n_runs++;
      modes.push_back(bus.MAIN_MODE);
      subs.push_back(bus.SUB_MODE);
    end
    clr_prev = bus.CLR;
    if (bus.DONE) n_done++;
    if (bus.CFG_ERR) n_cfg++;
    if (bus.BUSY && bus.MAIN_MODE == 8'd0) zero_seen = 1'b1;
    if (bus.BUSY && bus.MAIN_MODE == 8'd7 && !bus.CLR) n_m7++;
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic clear_stats();
    n_busy = 0; n_clr = 0; n_runs = 0; n_done = 0; n_cfg = 0; n_m7 = 0;
    zero_seen = 1'b0;
    modes.delete();
    subs.delete();
  endtask
  task automatic start(input logic [7:0] f, input logic [7:0] l, input logic [23:0] dw);
    clear_stats();
    bus.FIRST_MODE = f;
    bus.LAST_MODE  = l;
    bus.DWELL      = dw;
    bus.START      = 1'b1;
    tick();
    bus.START = 1'b0;
    check("start_busy", bus.BUSY, 1);
    check("start_clr", bus.CLR, 1);
    check("start_main", bus.MAIN_MODE, f);
  endtask
  task automatic run(input logic [7:0] f, input logic [7:0] l, input logic [23:0] dw);
    start(f, l, dw);
    for (int i = 0; i < 5000 && !bus.DONE; i++) tick();
    check("done_seen", bus.DONE, 1);
    check("done_busy_low", bus.BUSY, 0);
    tick();
    check("done_pulse_len", bus.DONE, 0);
  endtask
  initial begin
    bus.START = 1'b0; bus.ABORT = 1'b0;
    bus.FIRST_MODE = '0; bus.LAST_MODE = '0; bus.DWELL = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_first_fail", bus.FIRST_FAIL, 8'hFF);
    check("rst_fail_cnt", bus.FAIL_CNT, 0);
    check("rst_main", bus.MAIN_MODE, 0);
    check("rst_sub", bus.SUB_MODE, 0);
    check("rst_busy", bus.BUSY, 0);
    check("rst_clr", bus.CLR, 0);
    check("rst_done", bus.DONE, 0);
    check("rst_cfg_err", bus.CFG_ERR, 0);
    RSTX = 1'b1;
    tick();
    // bad range: rejected with a one-cycle CFG_ERR
    clear_stats();
    bus.FIRST_MODE = 8'd9; bus.LAST_MODE = 8'd2; bus.DWELL = 24'd10; bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    check("cfg_pulse", bus.CFG_ERR, 1);
    check("cfg_busy", bus.BUSY, 0);
    tick();
    check("cfg_pulse_end", bus.CFG_ERR, 0);
    check("cfg_main", bus.MAIN_MODE, 0);
    repeat (3) tick();
    check("cfg_count", n_cfg, 1);
    check("cfg_no_busy", n_busy, 0);
    // clean sweep 3..5: per run 4 clear + 1 settle + 10 dwell + check + next
    run(8'd3, 8'd5, 24'd10);
    check("t1_busy_cycles", n_busy, 51 * RUNS);
    check("t1_clr_cycles", n_clr, CLR_CYC * 3 * RUNS);
    check("t1_runs", n_runs, 3 * RUNS);
    check("t1_mode_first", modes[0], 3);
    check("t1_mode_mid", modes[RUNS], 4);
    check("t1_mode_last", modes[$], 5);
    check("t1_sub_last", subs[$], RUNS - 1);
    check("t1_done_cnt", n_done, 1);
    check("t1_fail_cnt", bus.FAIL_CNT, 0);
    check("t1_first_fail", bus.FIRST_FAIL, 8'hFF);
    // errors only in mode 4
    err_mode = 4;
    run(8'd3, 8'd5, 24'd10);
    err_mode = -1;
    check("t2_fail_cnt", bus.FAIL_CNT, RUNS);
    check("t2_first_fail", bus.FIRST_FAIL, 4);
    check("t2_busy_cycles", n_busy, 51 * RUNS);
    // mode 7 never initialises: settle timeout plus the NEXT cycle
    bad_mode = 7;
    run(8'd6, 8'd8, 24'd10);
    bad_mode = -1;
    check("t3_fail_cnt", bus.FAIL_CNT, RUNS);
    check("t3_first_fail", bus.FIRST_FAIL, 7);
    check("t3_m7_cycles", n_m7, RUNS * (INIT_TIMEOUT + 1));
    check("t3_busy_cycles", n_busy, RUNS * (34 + CLR_CYC + INIT_TIMEOUT + 1));
    // top of range: no wrap to 0
    run(8'd254, 8'd255, 24'd3);
    check("t5_runs", n_runs, 2 * RUNS);
    check("t5_mode_first", modes[0], 254);
    check("t5_mode_last", modes[$], 255);
    check("t5_no_zero", zero_seen, 0);
    check("t5_busy_cycles", n_busy, 20 * RUNS);
    check("t5_done_cnt", n_done, 1);
    // abort mid-dwell at cycle 16; mode 1 has already failed
    err_all = 1'b1;
    start(8'd1, 8'd9, 24'd3);
    repeat (16) tick();
    check("ab_pre_busy", bus.BUSY, 1);
    bus.ABORT = 1'b1;
    tick();
    bus.ABORT = 1'b0;
    err_all = 1'b0;
    check("ab_busy", bus.BUSY, 0);
    check("ab_main", bus.MAIN_MODE, 0);
    check("ab_sub", bus.SUB_MODE, 0);
    check("ab_clr", bus.CLR, 0);
    check("ab_fail_held", bus.FAIL_CNT, 1);
    check("ab_first_fail_held", bus.FIRST_FAIL, 1);
    repeat (20) tick();
    check("ab_no_done", n_done, 0);
    check("ab_stays_idle", bus.BUSY, 0);
    // abort beats start in idle
    clear_stats();
    bus.FIRST_MODE = 8'd3; bus.LAST_MODE = 8'd5; bus.START = 1'b1; bus.ABORT = 1'b1;
    tick();
    bus.START = 1'b0; bus.ABORT = 1'b0;
    check("abst_busy", bus.BUSY, 0);
    check("abst_main", bus.MAIN_MODE, 0);
    tick();
    check("abst_busy_later", bus.BUSY, 0);
    check("abst_fail_held", bus.FAIL_CNT, 1);
`ifdef MODE_SEQ_SUBSWEEP_EN
    err_all = 1'b1;
    run(8'd46, 8'd46, 24'd5);
    err_all = 1'b0;
    check("t6_runs", n_runs, 2);
    check("t6_sub0", subs[0], 0);
    check("t6_sub1", subs[1], 1);
    check("t6_fail_cnt", bus.FAIL_CNT, 2);
    check("t6_first_fail", bus.FIRST_FAIL, 46);
    check("t6_sub_end", bus.SUB_MODE, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
